// File: rtl/rf_alu_sequencer.sv
// ---------------------------------------------------------------------------
// rf_alu_sequencer
//
// Multi-cycle controller that steps one instruction through the 8x8 register
// file and the 5-op ULA. An instruction is accepted on a valid/ready
// handshake. Its sources are read, rs1 OP (rs2 | imm) is executed, the result
// is written to rd (never to r0), and the retired result/Z are reported.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   instr_valid/ready handshake for one instruction (ready only in IDLE)
//   instr_op/rd/rs1/rs2/imm_en/imm   instruction fields, captured on accept
//   rf_we3/wa3/wd3    register file write port (pulses for one cycle)
//   rf_ra1/ra2        register file read addresses
//   rf_rd1/rd2        register file read data (combinational read)
//   alu_srca/srcb/ctrl  ULA operands and control (op passed through)
//   alu_result/zero   ULA outputs
//   busy              high whenever not IDLE
//   done              one-cycle pulse when an instruction retires
//   result/zero_flag  result and Z of the last retired instruction
// ---------------------------------------------------------------------------
module rf_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_wa3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic              imm_en_q;
  logic [DATA_W-1:0] imm_q;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] res_q;
  logic              z_q;

  logic              accept;
  logic              rd_is_zero;

  assign accept     = (state == S_IDLE) && instr_valid;
  assign rd_is_zero = (rd_q == '0);

  // Only IDLE waits on the handshake; every other state advances each cycle.
  // r0 is hardwired zero, so an rd of 0 skips the WRITE state entirely.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_valid) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = rd_is_zero ? S_DONE : S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Instruction fields are captured once on accept, so the source may change
  // them freely while the sequencer is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else if (accept) begin
      op_q     <= instr_op;
      rd_q     <= instr_rd;
      rs1_q    <= instr_rs1;
      rs2_q    <= instr_rs2;
      imm_en_q <= instr_imm_en;
      imm_q    <= instr_imm;
    end
  end

  // Operands are latched at the end of READ, before any write of this
  // instruction, so rs1/rs2 == rd needs no hazard handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == S_READ) begin
      op_a <= rf_rd1;
      op_b <= imm_en_q ? imm_q : rf_rd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      z_q   <= 1'b0;
    end else if (state == S_EXEC) begin
      res_q <= alu_result;
      z_q   <= alu_zero;
    end
  end

  // Retired result updates on the edge entering DONE. When WRITE is skipped
  // that edge is the same one that latches res_q, so take the ULA directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero_flag <= 1'b0;
    end else if (state == S_EXEC && rd_is_zero) begin
      result    <= alu_result;
      zero_flag <= alu_zero;
    end else if (state == S_WRITE) begin
      result    <= res_q;
      zero_flag <= z_q;
    end
  end

  // Write enable is decoded from the state register, so asserting reset
  // clears it immediately and no partial write can happen.
  assign rf_we3      = (state == S_WRITE);
  assign rf_wa3      = rd_q;
  assign rf_wd3      = res_q;
  assign rf_ra1      = rs1_q;
  assign rf_ra2      = rs2_q;
  assign alu_srca    = op_a;
  assign alu_srcb    = op_b;
  assign alu_ctrl    = op_q;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule
